// File: rtl/hart_stimulus_gen.sv
// Walks the 6-bit hart stimulus toward a loaded target, holding each value.
// Optional one-sample glitch injection when HART_GLITCH_EN is defined.
module hart_stimulus_gen #(
  parameter int unsigned INIT = 40,
  parameter int unsigned HOLD = 8,
  parameter int unsigned STEP = 1
) (
  input  logic       slow,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] target,
  input  logic       glitch,
  output logic [5:0] hart,
  output logic       busy,
  output logic       stapPuls,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [7:0] CEND = 8'(HOLD - 1);
  localparam logic [6:0] SMAX = 7'(STEP);
  localparam logic [5:0] IVAL = 6'(INIT);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [5:0] tgt, tgt_n;
  logic [5:0] val, val_n;
  logic [5:0] hart_n;
  logic [6:0] diff;
  logic [5:0] stp;
  logic       dn;
  logic       at_end;
  logic       stap_n;
  logic       glitch_act;

  always_comb begin
    dn     = val > tgt;
    diff   = dn ? ({1'b0, val} - {1'b0, tgt})
                : ({1'b0, tgt} - {1'b0, val});
    stp    = (diff < SMAX) ? diff[5:0] : SMAX[5:0];
    at_end = cnt == CEND;
  end

`ifdef HART_GLITCH_EN
  // A glitch restarts the hold, except on an edge that takes a step.
  assign glitch_act = (state == S_HOLD) && glitch
                    && !(at_end && (val != tgt));
`else
  assign glitch_act = 1'b0 & glitch;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tgt_n   = tgt;
    val_n   = val;
    stap_n  = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (start) begin
          state_n = S_HOLD;
          tgt_n   = target;
          cnt_n   = 8'd0;
        end
      end
      (state == S_HOLD): begin
        if (glitch_act) begin
          cnt_n = 8'd0;
        end else if (!at_end) begin
          cnt_n = cnt + 8'd1;
        end else if (val == tgt) begin
          state_n = S_DONE;
        end else begin
          val_n  = dn ? (val - stp) : (val + stp);
          stap_n = 1'b1;
          cnt_n  = 8'd0;
        end
      end
      (state == S_DONE): begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    hart_n = glitch_act ? (val ^ 6'd1) : val_n;
  end

  always_ff @(posedge slow) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      tgt      <= IVAL;
      val      <= IVAL;
      hart     <= IVAL;
      busy     <= 1'b0;
      stapPuls <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tgt      <= tgt_n;
      val      <= val_n;
      hart     <= hart_n;
      busy     <= state_n == S_HOLD;
      stapPuls <= stap_n;
      done     <= state_n == S_DONE;
    end
  end

endmodule

// File: tb/tb_hart_stimulus_gen.sv
// Randomized and directed bench for hart_stimulus_gen.
// Reference model derives outputs from walk origin and elapsed edges.
module tb_hart_stimulus_gen;

`ifdef HART_GLITCH_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  logic       slow;
  logic       reset;
  logic       start;
  logic [5:0] target;
  logic       glitch;
  logic [5:0] hart0, hart1;
  logic       busy0, busy1;
  logic       stap0, stap1;
  logic       done0, done1;

  hart_stimulus_gen #(
    .INIT(40), .HOLD(8), .STEP(1)
  ) u0 (
    .slow(slow), .reset(reset),
    .start(start), .target(target),
    .glitch(glitch), .hart(hart0),
    .busy(busy0), .stapPuls(stap0),
    .done(done0)
  );

  hart_stimulus_gen #(
    .INIT(40), .HOLD(4), .STEP(4)
  ) u1 (
    .slow(slow), .reset(reset),
    .start(start), .target(target),
    .glitch(glitch), .hart(hart1),
    .busy(busy1), .stapPuls(stap1),
    .done(done1)
  );

  initial slow = 1'b0;
  always #5 slow = ~slow;

  int checks = 0;
  int errors = 0;
  int t = 0;

  bit act[2];
  int o[2], b[2], tg[2], cur[2];
  int eh[2];
  bit eb[2], es[2], ed[2];

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int mv(int v, int g, int a);
    if (g > v) return (v + a > g) ? g : v + a;
    return (v - a < g) ? g : v - a;
  endfunction

  function automatic int nst(int v, int g, int s);
    int d;
    d = (g > v) ? g - v : v - g;
    return (d + s - 1) / s;
  endfunction

  // Walk = origin edge o, base value b; step every h edges.
  task automatic model(int i, int h, int s);
    bit gf;
    int rel, n, k;
    gf = 1'b0;
    if (!reset) begin
      act[i] = 1'b0;
      cur[i] = 40;
    end else if (act[i]) begin
      rel = t - o[i];
      n   = nst(b[i], tg[i], s);
      if (rel == (n + 1) * h + 1) begin
        act[i] = 1'b0;
        cur[i] = tg[i];
      end else if (GEN && glitch && rel >= 1
                   && !(rel % h == 0 && rel / h <= n)) begin
        b[i] = mv(b[i], tg[i], (rel / h) * s);
        o[i] = t;
        gf   = 1'b1;
      end
    end else if (start) begin
      act[i] = 1'b1;
      o[i]   = t;
      b[i]   = cur[i];
      tg[i]  = int'(target);
    end
    if (act[i]) begin
      rel   = t - o[i];
      n     = nst(b[i], tg[i], s);
      k     = rel / h;
      eh[i] = mv(b[i], tg[i], k * s) ^ int'(gf);
      eb[i] = rel < (n + 1) * h;
      ed[i] = rel == (n + 1) * h;
      es[i] = rel > 0 && rel % h == 0 && k <= n;
    end else begin
      eh[i] = cur[i];
      eb[i] = 1'b0;
      ed[i] = 1'b0;
      es[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge slow);
    t++;
    model(0, 8, 1);
    model(1, 4, 4);
    #1;
    chk("u0.hart", int'(hart0), eh[0]);
    chk("u0.busy", int'(busy0), int'(eb[0]));
    chk("u0.stap", int'(stap0), int'(es[0]));
    chk("u0.done", int'(done0), int'(ed[0]));
    chk("u1.hart", int'(hart1), eh[1]);
    chk("u1.busy", int'(busy1), int'(eb[1]));
    chk("u1.stap", int'(stap1), int'(es[1]));
    chk("u1.done", int'(done1), int'(ed[1]));
    @(negedge slow);
  endtask

  task automatic wait_idle(int lim);
    for (int k = 0; k < lim && (act[0] || act[1]); k++)
      tick();
    chk("idle.timeout", int'(act[0] || act[1]), 0);
    chk("idle.busy0", int'(busy0), 0);
  endtask

  task automatic walk(int tv);
    start  = 1'b1;
    target = 6'(tv);
    tick();
    start  = 1'b0;
    wait_idle(1000);
  endtask

  initial begin
    act    = '{1'b0, 1'b0};
    cur    = '{40, 40};
    reset  = 1'b0;
    start  = 1'b0;
    target = 6'd0;
    glitch = 1'b0;
    @(negedge slow);

    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst.hart", int'(hart0), 40);
    chk("rst.busy", int'(busy0), 0);
    chk("rst.done", int'(done0), 0);
    chk("rst.stap", int'(stap0), 0);

    start  = 1'b1;
    target = 6'd37;
    tick();
    start  = 1'b0;
    repeat (8) tick();
    chk("down.e8", int'(hart0), 39);
    repeat (8) tick();
    chk("down.e16", int'(hart0), 38);
    repeat (8) tick();
    chk("down.e24", int'(hart0), 37);
    repeat (8) tick();
    chk("down.done", int'(done0), 1);
    tick();
    chk("down.idle", int'(done0), 0);
    wait_idle(100);

    walk(42);
    walk(2);
    walk(0);
    chk("clamp.u1", int'(hart1), 0);

    start  = 1'b1;
    target = 6'd0;
    tick();
    start  = 1'b0;
    tick();
    tick();
    start  = 1'b1;
    target = 6'd10;
    tick();
    start  = 1'b0;
    wait_idle(100);
    chk("eq.hold", int'(hart0), 0);

    start  = 1'b1;
    target = 6'd30;
    tick();
    start  = 1'b0;
    repeat (19) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst.hart", int'(hart0), 40);
    chk("midrst.busy", int'(busy0), 0);
    walk(45);

    start  = 1'b1;
    target = 6'd30;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    chk("glitch.hart", int'(hart0), GEN ? 44 : 45);
    wait_idle(1000);

    for (int c = 0; c < 3000; c++) begin
      reset  = $urandom_range(0, 299) != 0;
      start  = $urandom_range(0, 7) == 0;
      target = 6'($urandom);
      glitch = $urandom_range(0, 15) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
